// File: rtl/xaui_tx_idle_sched_pkg.sv
// ==== xaui_tx_idle_sched_pkg: XAUI symbol constants and TX column classes ====
// ==== rev 1.0                                                              ====
`default_nettype none

package xaui_tx_idle_sched_pkg;

  localparam logic [7:0] SYM_IDLE  = 8'h07;
  localparam logic [7:0] SYM_K     = 8'hBC;
  localparam logic [7:0] SYM_A     = 8'h7C;
  localparam logic [7:0] SYM_R     = 8'h1C;
  localparam logic [7:0] SYM_START = 8'hFB;
  localparam logic [7:0] SYM_TERM  = 8'hFD;
  localparam logic [7:0] SYM_SEQ   = 8'h9C;
  localparam logic [7:0] SYM_ERR   = 8'hFE;

  localparam logic [6:0] LFSR_SEED = 7'h7F;

  typedef enum logic [1:0] {
    COL_IDLE      = 2'd0,
    COL_POST_IDLE = 2'd1,
    COL_TERM      = 2'd2,
    COL_DATA      = 2'd3
  } col_class_t;

  // Control codes allowed to reach the encoder unchanged inside a frame.
  function automatic logic is_pass_ctrl(input logic [7:0] b);
    return (b == SYM_START) || (b == SYM_TERM) || (b == SYM_SEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/xaui_idle_lfsr.sv
// ==== xaui_idle_lfsr: free-running x^7+x^6+1 LFSR driving idle K/R and A spacing ====
// ==== rev 1.0                                                                     ====
`default_nettype none

module xaui_idle_lfsr
  import xaui_tx_idle_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] lfsr_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_o <= LFSR_SEED;
    end else begin
      lfsr_o <= {lfsr_o[5:0], lfsr_o[6] ^ lfsr_o[5]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/xaui_tx_idle_sched.sv
// ==== xaui_tx_idle_sched: XGMII-to-XAUI TX column scheduler, one-cycle registered ====
// ==== rev 1.0                                                                     ====
`default_nettype none

module xaui_tx_idle_sched
  import xaui_tx_idle_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] txd_i,
  input  logic [3:0]  txc_i,
  input  logic        en_i,
  output logic [31:0] data_o,
  output logic [3:0]  isk_o,
  output logic        a_col_o
);

  logic [6:0]  lfsr;
  logic        lfsr_unused;
  logic [4:0]  a_cnt;
  logic [4:0]  a_cnt_next;
  logic        post_term;
  logic        post_term_next;
  logic        reload;
  logic        is_idle;
  logic        has_term;
  logic [1:0]  term_lane;
  col_class_t  col_class;
  logic [31:0] data_next;
  logic [3:0]  isk_next;
  logic        a_col_next;

  xaui_idle_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .lfsr_o (lfsr)
  );

  assign lfsr_unused = ^lfsr[6:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      data_o    <= {4{SYM_K}};
      isk_o     <= 4'hF;
      a_col_o   <= 1'b0;
      a_cnt     <= 5'd0;
      post_term <= 1'b0;
    end else begin
      data_o    <= data_next;
      isk_o     <= isk_next;
      a_col_o   <= a_col_next;
      a_cnt     <= a_cnt_next;
      post_term <= post_term_next;
    end
  end

  // Classification; descending scan so the lowest TERM lane wins.
  always_comb begin
    is_idle   = !en_i || (txc_i == 4'hF && txd_i == {4{SYM_IDLE}});
    has_term  = 1'b0;
    term_lane = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (txc_i[n] && txd_i[8*n +: 8] == SYM_TERM) begin
        has_term  = 1'b1;
        term_lane = 2'(n);
      end
    end
    if (is_idle)       col_class = post_term ? COL_POST_IDLE : COL_IDLE;
    else if (has_term) col_class = COL_TERM;
    else               col_class = COL_DATA;
  end

  always_comb begin
    data_next      = {4{SYM_K}};
    isk_next       = 4'hF;
    a_col_next     = 1'b0;
    reload         = 1'b0;
    post_term_next = 1'b0;
    case (col_class)
      COL_IDLE: begin
        if (a_cnt == 5'd0) begin
          data_next  = {4{SYM_A}};
          a_col_next = 1'b1;
          reload     = 1'b1;
        end else if (lfsr[0]) begin
          data_next = {4{SYM_R}};
        end
      end
      COL_TERM: begin
        post_term_next = 1'b1;
        for (int n = 0; n < 4; n++) begin
          if (n < int'(term_lane)) begin
            data_next[8*n +: 8] = txd_i[8*n +: 8];
            isk_next[n]         = txc_i[n];
          end else if (n == int'(term_lane)) begin
            data_next[8*n +: 8] = SYM_TERM;
          end
        end
      end
      COL_DATA: begin
        for (int n = 0; n < 4; n++) begin
          if (!txc_i[n]) begin
            data_next[8*n +: 8] = txd_i[8*n +: 8];
            isk_next[n]         = 1'b0;
          end else if (is_pass_ctrl(txd_i[8*n +: 8])) begin
            data_next[8*n +: 8] = txd_i[8*n +: 8];
          end else begin
            data_next[8*n +: 8] = SYM_ERR;
          end
        end
      end
      default: ;
    endcase
  end

  // Reload takes precedence over the saturating decrement.
  assign a_cnt_next = reload            ? {1'b1, lfsr[3:0]} :
                      (a_cnt != 5'd0)   ? a_cnt - 5'd1 : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_xaui_tx_idle_sched.sv
// ==== tb_xaui_tx_idle_sched: randomized bench against a column-level reference model ====
// ==== rev 1.0                                                                         ====
`default_nettype none

module tb_xaui_tx_idle_sched;

  logic        clk;
  logic        reset;
  logic [31:0] txd_i;
  logic [3:0]  txc_i;
  logic        en_i;
  logic [31:0] data_o;
  logic [3:0]  isk_o;
  logic        a_col_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_lfsr = 127;
  int m_cnt  = 0;
  bit m_prev = 0;

  xaui_tx_idle_sched dut (
    .clk     (clk),
    .reset   (reset),
    .txd_i   (txd_i),
    .txc_i   (txc_i),
    .en_i    (en_i),
    .data_o  (data_o),
    .isk_o   (isk_o),
    .a_col_o (a_col_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [31:0] d, input logic [3:0] c, input logic e, input logic r,
                       output logic [31:0] ed, output logic [3:0] ek, output logic ea);
    bit idle;
    int tl;
    int reload;
    int b;
    ed = 32'hBCBCBCBC;
    ek = 4'hF;
    ea = 1'b0;
    if (r) begin
      m_lfsr = 127;
      m_cnt  = 0;
      m_prev = 0;
    end else begin
      idle   = !e || (c == 4'hF && d == 32'h07070707);
      reload = -1;
      tl     = -1;
      for (int n = 0; n < 4; n++)
        if (tl < 0 && c[n] && d[8*n +: 8] == 8'hFD) tl = n;
      if (idle) begin
        if (!m_prev) begin
          if (m_cnt == 0) begin
            ed = 32'h7C7C7C7C; ea = 1'b1; reload = 16 + (m_lfsr % 16);
          end else if (m_lfsr % 2 == 1) begin
            ed = 32'h1C1C1C1C;
          end
        end
        m_prev = 0;
      end else if (tl >= 0) begin
        for (int n = 0; n < 4; n++) begin
          if (n < tl) begin ed[8*n +: 8] = d[8*n +: 8]; ek[n] = c[n]; end
          else if (n == tl) ed[8*n +: 8] = 8'hFD;
        end
        m_prev = 1;
      end else begin
        for (int n = 0; n < 4; n++) begin
          b = int'(d[8*n +: 8]);
          if (!c[n]) begin ed[8*n +: 8] = d[8*n +: 8]; ek[n] = 1'b0; end
          else if (b == 'hFB || b == 'hFD || b == 'h9C) ed[8*n +: 8] = d[8*n +: 8];
          else ed[8*n +: 8] = 8'hFE;
        end
        m_prev = 0;
      end
      m_cnt  = (reload >= 0) ? reload : ((m_cnt > 0) ? m_cnt - 1 : 0);
      m_lfsr = ((m_lfsr << 1) & 'h7F) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
    end
  endtask

  task automatic step(input logic [31:0] d, input logic [3:0] c, input logic e, input logic r);
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        ea;
    txd_i = d; txc_i = c; en_i = e; reset = r;
    model(d, c, e, r, ed, ek, ea);
    @(posedge clk); #1;
    check("data", data_o, ed);
    check("isk", {28'd0, isk_o}, {28'd0, ek});
    check("a_col", {31'd0, a_col_o}, {31'd0, ea});
  endtask

  localparam logic [31:0] IDLE_D = 32'h07070707;

  task automatic rand_col(output logic [31:0] d, output logic [3:0] c, output logic e);
    int kind;
    int lane;
    kind = int'($urandom_range(0, 99));
    e = ($urandom_range(0, 9) != 0);
    d = $urandom;
    c = 4'($urandom);
    if (kind < 40) begin
      d = IDLE_D; c = 4'hF;
    end else if (kind < 55) begin
      lane = int'($urandom_range(0, 3));
      d[8*lane +: 8] = 8'hFD; c[lane] = 1'b1;
    end else if (kind < 65) begin
      lane = int'($urandom_range(0, 3));
      d[8*lane +: 8] = ($urandom_range(0, 1) != 0) ? 8'hFB : 8'h9C;
      c[lane] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  c;
    logic        e;
    int          last_a;
    int          gap;
    txd_i = IDLE_D; txc_i = 4'hF; en_i = 1'b1; reset = 1'b1;

    for (int i = 0; i < 3; i++) step(IDLE_D, 4'hF, 1'b1, 1'b1);
    check("rst_data", data_o, 32'hBCBCBCBC);
    check("rst_isk", {28'd0, isk_o}, 32'hF);
    check("rst_acol", {31'd0, a_col_o}, 32'd0);

    // Continuous idle: first ||A||, then gaps of 17..32 columns.
    step(IDLE_D, 4'hF, 1'b1, 1'b0);
    check("first_A", data_o, 32'h7C7C7C7C);
    last_a = 0;
    for (int i = 1; i < 1000; i++) begin
      step(IDLE_D, 4'hF, 1'b1, 1'b0);
      check("idle_isk", {28'd0, isk_o}, 32'hF);
      if (a_col_o) begin
        gap = i - last_a;
        check("a_gap_ok", {31'd0, (gap >= 17 && gap <= 32)}, 32'd1);
        last_a = i;
      end
    end

    // Directed columns with literal expectations.
    step(32'hFD555555, 4'b1000, 1'b1, 1'b0);
    check("term3_d", data_o, 32'hFD555555);
    check("term3_k", {28'd0, isk_o}, 32'h8);
    step(IDLE_D, 4'hF, 1'b1, 1'b0);
    check("post_K", data_o, 32'hBCBCBCBC);
    check("post_Kk", {28'd0, isk_o}, 32'hF);
    step(32'h0707FDAA, 4'b1110, 1'b1, 1'b0);
    check("term1_d", data_o, 32'hBCBCFDAA);
    check("term1_k", {28'd0, isk_o}, 32'hE);
    step(32'h07AABBCC, 4'b1000, 1'b1, 1'b0);
    check("err07_d", data_o, 32'hFEAABBCC);
    check("err07_k", {28'd0, isk_o}, 32'h8);
    step(32'h11223C44, 4'b0010, 1'b1, 1'b0);
    check("err3c_d", data_o, 32'h1122FE44);
    check("err3c_k", {28'd0, isk_o}, 32'h2);
    step(32'hFDFD0011, 4'b1100, 1'b1, 1'b0);
    check("multi_term", data_o, 32'hBCFD0011);

    // Reset pulse mid-packet.
    step(32'hFB112233, 4'b1000, 1'b1, 1'b0);
    step(32'h44556677, 4'b0000, 1'b1, 1'b1);
    check("midrst_d", data_o, 32'hBCBCBCBC);
    check("midrst_k", {28'd0, isk_o}, 32'hF);
    step(32'h8899AABB, 4'b0000, 1'b1, 1'b0);

    // Enable dropped over a packet: idle-only output.
    for (int i = 0; i < 8; i++) begin
      step($urandom, 4'($urandom), 1'b0, 1'b0);
      check("en0_k", {28'd0, isk_o}, 32'hF);
      check("en0_idle", {31'd0, (data_o == 32'h7C7C7C7C || data_o == 32'hBCBCBCBC ||
                                 data_o == 32'h1C1C1C1C)}, 32'd1);
    end

    for (int i = 0; i < 3000; i++) begin
      rand_col(d, c, e);
      step(d, c, e, ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
